// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and state encoding for the register-file writeback arbiter.
// Imported by the arbiter top and its round-robin picker.
package reg_wb_arbiter_pkg;

    localparam int WORD_W    = 64;
    localparam int REG_IDX_W = 5;
    localparam int ZR_IDX    = 31;
    localparam int NUM_REGS  = 32;

    // Scrub covers X0..X30; X31 is the hard-wired zero register.
    localparam logic [REG_IDX_W-1:0] LAST_CLR_IDX = REG_IDX_W'(NUM_REGS - 2);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr_i,
// wrapping modulo N, wins. The picker returns a one-hot grant and the winner index.
module rr_arbiter #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand [N];
    logic          found;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = IW'((int'(ptr_i) + gi) % N);
        end
    endgenerate

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[cand[k]]) begin
                found            = 1'b1;
                gnt_o[cand[k]]   = 1'b1;
                idx_o            = cand[k];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port among NREQ writeback requesters with
// round-robin valid/ready arbitration, plus a sequencer that zeroes X0..X30.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int  NREQ    = 2,
    parameter int  WORD    = WORD_W,
    parameter int  XZR_IDX = ZR_IDX,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*REG_IDX_W-1:0] req_reg,
    input  logic [NREQ*WORD-1:0]      req_data,
    input  logic                      clr_start,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [REG_IDX_W-1:0]      w_reg,
    output logic [WORD-1:0]           w_data,
    output logic                      RegWrite,
    output logic [IW-1:0]             grant_id
);

    state_t               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        rr_ptr_d;
    logic [REG_IDX_W-1:0] clr_cnt_q;
    logic [REG_IDX_W-1:0] w_reg_q;
    logic [WORD-1:0]      w_data_q;
    logic                 regwrite_q;
    logic [IW-1:0]        grant_id_q;
    logic                 clr_done_q;

    logic [REG_IDX_W-1:0] reg_arr  [NREQ];
    logic [WORD-1:0]      data_arr [NREQ];
    logic [NREQ-1:0]      gnt;
    logic [IW-1:0]        win_idx;
    logic                 win_any;
    logic                 accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign reg_arr[gi]  = req_reg[REG_IDX_W*gi +: REG_IDX_W];
            assign data_arr[gi] = req_data[WORD*gi +: WORD];
        end
    endgenerate

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // clr_start pre-empts any pending request in the cycle it arrives.
    assign accept    = rst_n && (state_q == RUN) && !clr_start && win_any;
    assign req_ready = accept ? gnt : '0;
    assign rr_ptr_d  = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            rr_ptr_q   <= '0;
            clr_cnt_q  <= '0;
            w_reg_q    <= '0;
            w_data_q   <= '0;
            regwrite_q <= 1'b0;
            grant_id_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            regwrite_q <= 1'b0;
            clr_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (clr_start) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                    end else if (accept) begin
                        rr_ptr_q   <= rr_ptr_d;
                        w_reg_q    <= reg_arr[win_idx];
                        w_data_q   <= data_arr[win_idx];
                        regwrite_q <= (reg_arr[win_idx] != REG_IDX_W'(XZR_IDX));
                        grant_id_q <= win_idx;
                    end
                end
                CLEAR: begin
                    w_reg_q    <= clr_cnt_q;
                    w_data_q   <= '0;
                    regwrite_q <= 1'b1;
                    clr_cnt_q  <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_CLR_IDX) begin
                        state_q    <= RUN;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign w_reg    = w_reg_q;
    assign w_data   = w_data_q;
    assign RegWrite = regwrite_q;
    assign grant_id = grant_id_q;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

endmodule
